ext_mem_model: RTL and testbench

Parametrised multi-channel off-chip memory slave for HLS top-level simulation and emulation. It generalises the fixed two-channel, 8-bit-lane testbench memory to CHANNELS ports of DATA_W bits, with independent read and write latencies and multi-byte little-endian accesses. It also adds a byte preload port and per-channel protocol error reporting. It sits between the accelerator's `Mout_*` master bus and its `S_*`/`M_*` return paths, and ORs in responses from on-chip slaves.

---
 rtl/ext_mem_model_if.sv | 34 +++
 rtl/ext_mem_model.sv | 125 ++++++++++++
 tb/tb_ext_mem_model.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_mem_model_if.sv
// Off-chip memory bus: master requests, on-chip slave returns, preload port and memory responses.
// The master modport drives requests; the slave modport is the memory model side.
interface ext_mem_model_if #(
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int SIZE_W   = 4
);
  logic [CHANNELS-1:0]        Mout_oe_ram;
  logic [CHANNELS-1:0]        Mout_we_ram;
  logic [CHANNELS*ADDR_W-1:0] Mout_addr_ram;
  logic [CHANNELS*DATA_W-1:0] Mout_Wdata_ram;
  logic [CHANNELS*SIZE_W-1:0] Mout_data_ram_size;
  logic [CHANNELS*DATA_W-1:0] Sout_Rdata_ram;
  logic [CHANNELS-1:0]        Sout_DataRdy;
  logic                       init_we;
  logic [ADDR_W-1:0]          init_addr;
  logic [7:0]                 init_data;
  logic [CHANNELS*DATA_W-1:0] M_Rdata_ram;
  logic [CHANNELS-1:0]        M_DataRdy;
  logic [CHANNELS-1:0]        err;

  modport master (
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    output Sout_Rdata_ram, Sout_DataRdy, init_we, init_addr, init_data,
    input  M_Rdata_ram, M_DataRdy, err
  );

  modport slave (
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    input  Sout_Rdata_ram, Sout_DataRdy, init_we, init_addr, init_data,
    output M_Rdata_ram, M_DataRdy, err
  );
endinterface

// File: rtl/ext_mem_model.sv
// Multi-channel byte-addressed memory slave: reads complete in READ_DELAY cycles, writes in WRITE_DELAY, master holds request until M_DataRdy.
// MEM_MODEL_ERR_CHECK_EN enables sticky per-channel protocol error detection (oe+we together, illegal size).
module ext_mem_model #(
  parameter int CHANNELS    = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int SIZE_W      = 4,
  parameter int MEM_BYTES   = 64,
  parameter int BASE_ADDR   = 0,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic            clock,
  input  logic            reset,
  ext_mem_model_if.slave  bus
);
  localparam int NB    = DATA_W / 8;
  localparam int MAXD  = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int CNT_W = $clog2(MAXD + 1);
  localparam int IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int PIPE  = READ_DELAY - 1;

  logic [7:0]          mem_q   [MEM_BYTES];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_d   [CHANNELS];
  logic [DATA_W-1:0]   pipe_q  [CHANNELS][PIPE];
  logic [DATA_W-1:0]   rd_word [CHANNELS];
  logic [CHANNELS-1:0] err_q, err_d;
  logic [CHANNELS-1:0] rd_req, wr_req, rd_fire, wr_fire, bad_req, legal, in_rng;
  int                  size_bits [CHANNELS];
  int                  nbytes    [CHANNELS];
  int                  base_off  [CHANNELS];

  function automatic logic [IDX_W-1:0] to_idx(input int i);
    return i[IDX_W-1:0];
  endfunction

  // Request decode; all local activity is suppressed while reset is held.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      size_bits[c] = int'(bus.Mout_data_ram_size[c*SIZE_W +: SIZE_W]);
      legal[c]     = ((size_bits[c] == 8) || (size_bits[c] == 16) ||
                      (size_bits[c] == 32) || (size_bits[c] == 64)) && (size_bits[c] <= DATA_W);
`ifdef MEM_MODEL_ERR_CHECK_EN
      bad_req[c]   = (bus.Mout_oe_ram[c] & bus.Mout_we_ram[c]) |
                     ((bus.Mout_oe_ram[c] | bus.Mout_we_ram[c]) & ~legal[c]);
`else
      bad_req[c]   = 1'b0;
      if (!legal[c]) size_bits[c] = DATA_W;
`endif
      nbytes[c]    = size_bits[c] / 8;
      base_off[c]  = int'(bus.Mout_addr_ram[c*ADDR_W +: ADDR_W]) - BASE_ADDR;
      in_rng[c]    = (base_off[c] >= 0) && (base_off[c] + nbytes[c] <= MEM_BYTES);
      rd_req[c]    = reset & bus.Mout_oe_ram[c] & in_rng[c] & ~bad_req[c];
      wr_req[c]    = reset & bus.Mout_we_ram[c] & ~bus.Mout_oe_ram[c] & in_rng[c] & ~bad_req[c];
      rd_fire[c]   = rd_req[c] && (cnt_q[c] == CNT_W'(READ_DELAY - 1));
      wr_fire[c]   = wr_req[c] && (cnt_q[c] == CNT_W'(WRITE_DELAY - 1));
      if ((rd_req[c] | wr_req[c]) && !(rd_fire[c] | wr_fire[c])) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end else begin
        cnt_d[c] = '0;
      end
    end
    err_d = err_q | bad_req;
  end

  // Little-endian assembly; bytes beyond the access size read as zero.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      rd_word[c] = '0;
      for (int b = 0; b < NB; b++) begin
        if (b < nbytes[c] && in_rng[c]) begin
          rd_word[c][b*8 +: 8] = mem_q[to_idx(base_off[c] + b)];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= '0;
        for (int s = 0; s < PIPE; s++) pipe_q[c][s] <= '0;
      end
    end else begin
      err_q <= err_d;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c]     <= cnt_d[c];
        pipe_q[c][0] <= rd_word[c];
        for (int s = 1; s < PIPE; s++) pipe_q[c][s] <= pipe_q[c][s-1];
      end
    end
  end

  // Later assignments win: preload loses to any channel, higher channel beats lower.
  always_ff @(posedge clock) begin
    if (bus.init_we && (int'(bus.init_addr) >= BASE_ADDR) &&
        (int'(bus.init_addr) < BASE_ADDR + MEM_BYTES)) begin
      mem_q[to_idx(int'(bus.init_addr) - BASE_ADDR)] <= bus.init_data;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_fire[c] && b < nbytes[c]) begin
          mem_q[to_idx(base_off[c] + b)] <= bus.Mout_Wdata_ram[c*DATA_W + b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    bus.M_DataRdy   = bus.Sout_DataRdy | rd_fire | wr_fire;
    bus.M_Rdata_ram = bus.Sout_Rdata_ram;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_fire[c]) begin
        bus.M_Rdata_ram[c*DATA_W +: DATA_W] = bus.Sout_Rdata_ram[c*DATA_W +: DATA_W] | pipe_q[c][PIPE-1];
      end
    end
`ifdef MEM_MODEL_ERR_CHECK_EN
    bus.err = err_q;
`else
    bus.err = '0;
`endif
  end
endmodule

// File: tb/tb_ext_mem_model.sv
// Directed bench for ext_mem_model: 2 channels, 32-bit lanes, read latency 2, write latency 3.
module tb_ext_mem_model;
  localparam int CH = 2, AW = 8, DW = 32, SW = 7, MB = 64, BA = 0, RD = 2, WD = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ext_mem_model_if #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW)) bus ();

  ext_mem_model #(
    .CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .MEM_BYTES(MB),
    .BASE_ADDR(BA), .READ_DELAY(RD), .WRITE_DELAY(WD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int ch);
    return bus.M_DataRdy[ch];
  endfunction

  function automatic logic [DW-1:0] rdat(input int ch);
    return bus.M_Rdata_ram[ch*DW +: DW];
  endfunction

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic req(input int ch, input logic oe, input logic we, input int a, input int size,
                     input logic [DW-1:0] wd);
    bus.Mout_oe_ram[ch]                = oe;
    bus.Mout_we_ram[ch]                = we;
    bus.Mout_addr_ram[ch*AW +: AW]     = AW'(a);
    bus.Mout_data_ram_size[ch*SW +: SW] = SW'(size);
    bus.Mout_Wdata_ram[ch*DW +: DW]    = wd;
  endtask

  task automatic idle(input int ch);
    req(ch, 1'b0, 1'b0, 0, 8, '0);
  endtask

  task automatic preload(input int a, input logic [7:0] d);
    bus.init_we   = 1'b1;
    bus.init_addr = AW'(a);
    bus.init_data = d;
    next_cyc();
    bus.init_we   = 1'b0;
  endtask

  task automatic do_read(input string tag, input int ch, input int a, input int size,
                         input logic [DW-1:0] exp);
    req(ch, 1'b1, 1'b0, a, size, '0);
    smp();
    chk({tag, "_rdy_c1"}, 64'(rdy(ch)), 64'd0);
    next_cyc();
    smp();
    chk({tag, "_rdy_c2"}, 64'(rdy(ch)), 64'd1);
    chk({tag, "_dat"}, 64'(rdat(ch)), 64'(exp));
    next_cyc();
    idle(ch);
  endtask

  task automatic do_write(input string tag, input int ch, input int a, input int size,
                          input logic [DW-1:0] wd);
    req(ch, 1'b0, 1'b1, a, size, wd);
    for (int k = 1; k <= WD; k++) begin
      smp();
      chk({tag, "_rdy"}, 64'(rdy(ch)), (k == WD) ? 64'd1 : 64'd0);
      next_cyc();
    end
    idle(ch);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Mout_oe_ram        = '0;
    bus.Mout_we_ram        = '0;
    bus.Mout_addr_ram      = '0;
    bus.Mout_Wdata_ram     = '0;
    bus.Mout_data_ram_size = '0;
    bus.Sout_Rdata_ram     = '0;
    bus.Sout_DataRdy       = '0;
    bus.init_we            = 1'b0;
    bus.init_addr          = '0;
    bus.init_data          = '0;

    // Asynchronous reset: outputs clear before any clock edge.
    #2 reset = 1'b0;
    #1;
    chk("rst_rdy", 64'(bus.M_DataRdy), 64'd0);
    chk("rst_dat", 64'(bus.M_Rdata_ram), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);

    req(0, 1'b1, 1'b0, 4, 32, '0);
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      smp();
      chk("rst_hold_rdy", 64'(bus.M_DataRdy), 64'd0);
      chk("rst_hold_dat", 64'(bus.M_Rdata_ram), 64'd0);
      chk("rst_hold_err", 64'(bus.err), 64'd0);
    end
    next_cyc();
    idle(0);
    reset = 1'b1;
    next_cyc();

    preload(4, 8'h11);
    preload(5, 8'h22);
    preload(6, 8'h33);
    preload(7, 8'h44);
    preload(12, 8'h5A);
    preload(20, 8'h77);
    preload(30, 8'h3C);
    preload(63, 8'hC3);

    do_read("rd32", 0, 4, 32, 32'h4433_2211);
    smp();
    chk("rd32_rdy_c3", 64'(rdy(0)), 64'd0);
    next_cyc();
    do_read("rd16_unaligned", 1, 5, 16, 32'h0000_3322);

    do_write("wr16", 1, 10, 16, 32'hCAFE_BEEF);
    do_read("rd10", 0, 10, 8, 32'h0000_00EF);
    do_read("rd11", 1, 11, 8, 32'h0000_00BE);
    do_read("rd12", 0, 12, 8, 32'h0000_005A);
    do_read("rd10w", 0, 10, 16, 32'h0000_BEEF);

    // Same-edge writes from both channels plus a preload to the same byte.
    req(0, 1'b0, 1'b1, 20, 8, 32'h0000_00AA);
    req(1, 1'b0, 1'b1, 20, 8, 32'h0000_0055);
    smp(); next_cyc();
    smp(); next_cyc();
    bus.init_we = 1'b1; bus.init_addr = 8'd20; bus.init_data = 8'h99;
    smp();
    chk("se_rdy", 64'(bus.M_DataRdy), 64'd3);
    next_cyc();
    idle(0); idle(1);
    bus.init_we = 1'b0;
    do_read("se_byte", 0, 20, 8, 32'h0000_0055);

    // Read sampling on the same edge that commits a write sees the old byte.
    req(1, 1'b0, 1'b1, 20, 8, 32'h0000_0066);
    smp(); next_cyc();
    smp(); next_cyc();
    req(0, 1'b1, 1'b0, 20, 8, '0);
    smp();
    chk("rw_wr_rdy", 64'(rdy(1)), 64'd1);
    chk("rw_rd_rdy_c1", 64'(rdy(0)), 64'd0);
    next_cyc();
    idle(1);
    smp();
    chk("rw_rd_rdy_c2", 64'(rdy(0)), 64'd1);
    chk("rw_rd_old", 64'(rdat(0)), 64'h55);
    next_cyc();
    idle(0);
    do_read("rw_new", 1, 20, 8, 32'h0000_0066);

    // Out-of-range read straddling the top: only the on-chip slave answers.
    req(0, 1'b1, 1'b0, BA + MB - 1, 16, '0);
    smp();
    chk("oor_rdy_c1", 64'(rdy(0)), 64'd0);
    chk("oor_dat_c1", 64'(rdat(0)), 64'd0);
    next_cyc();
    bus.Sout_DataRdy[0] = 1'b1;
    bus.Sout_Rdata_ram[0 +: DW] = 32'h0000_1234;
    smp();
    chk("oor_rdy_c2", 64'(rdy(0)), 64'd1);
    chk("oor_dat_c2", 64'(rdat(0)), 64'h1234);
    next_cyc();
    bus.Sout_DataRdy = '0;
    bus.Sout_Rdata_ram = '0;
    smp();
    chk("oor_rdy_c3", 64'(rdy(0)), 64'd0);
    chk("oor_dat_c3", 64'(rdat(0)), 64'd0);
    next_cyc();
    idle(0);

    req(1, 1'b0, 1'b1, BA + MB - 1, 16, 32'h0000_FFFF);
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("oor_wr_rdy", 64'(rdy(1)), 64'd0);
      next_cyc();
    end
    idle(1);
    do_read("oor_keep", 0, BA + MB - 1, 8, 32'h0000_00C3);

    // Reset in the completing cycle of a write: no response, no commit.
    req(1, 1'b0, 1'b1, 30, 8, 32'h0000_00E1);
    smp(); next_cyc();
    smp(); next_cyc();
    reset = 1'b0;
    #1;
    chk("rstmid_rdy", 64'(rdy(1)), 64'd0);
    next_cyc();
    next_cyc();
    idle(1);
    reset = 1'b1;
    next_cyc();
    do_read("rstmid_keep", 0, 30, 8, 32'h0000_003C);

`ifdef MEM_MODEL_ERR_CHECK_EN
    req(0, 1'b1, 1'b1, 4, 32, '0);
    smp();
    chk("err_rdy", 64'(rdy(0)), 64'd0);
    next_cyc();
    idle(0);
    smp();
    chk("err_set", 64'(bus.err), 64'd1);
    repeat (3) next_cyc();
    smp();
    chk("err_sticky", 64'(bus.err), 64'd1);
    next_cyc();
    do_read("err_mem", 0, 4, 32, 32'h4433_2211);
`else
    req(0, 1'b1, 1'b1, 4, 32, '0);
    smp();
    chk("oewe_rdy_c1", 64'(rdy(0)), 64'd0);
    next_cyc();
    smp();
    chk("oewe_rdy_c2", 64'(rdy(0)), 64'd1);
    chk("oewe_dat", 64'(rdat(0)), 64'h4433_2211);
    next_cyc();
    idle(0);
    smp();
    chk("oewe_err", 64'(bus.err), 64'd0);
    next_cyc();
    do_read("oewe_mem", 0, 4, 32, 32'h4433_2211);
    do_read("clamp_size", 1, 4, 24, 32'h4433_2211);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
